// File: rtl/tcm_copy_engine.sv
// tcm_copy_engine
// Drives one port of the TCM dual-port SRAM. It either copies a block of words
// from a source address to a destination address, or fills a block with a
// constant pattern. At most one SRAM access is outstanding at any time.
// Every output comes straight from a flop. The output flops are loaded from
// the next-state value, so an access appears on the port in the same cycle
// that the FSM enters RD or WR.

module tcm_copy_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int N_ENTRIES  = 1024,
    parameter int ADDRW      = $clog2(N_ENTRIES)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    fill_i,
    input  logic [ADDRW-1:0]        src_addr_i,
    input  logic [ADDRW-1:0]        dst_addr_i,
    input  logic [ADDRW:0]          len_i,
    input  logic [DATA_WIDTH-1:0]   fill_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDRW-1:0]        mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i
);

    localparam int BEW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT_RD,
        WR,
        WAIT_WR,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic                    fill_q, fill_d;
    logic [ADDRW-1:0]        src_q, src_d;
    logic [ADDRW-1:0]        dst_q, dst_d;
    logic [ADDRW:0]          rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   pattern_q, pattern_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    en_q, en_d;
    logic                    we_q, we_d;
    logic [BEW-1:0]          be_q, be_d;
    logic [ADDRW-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    // Next-state logic: sequences one word at a time and updates the pointers
    // and the remaining count once each write has been acknowledged.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        pattern_d = pattern_q;
        data_d    = data_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    fill_d    = fill_i;
                    src_d     = src_addr_i;
                    dst_d     = dst_addr_i;
                    rem_d     = len_i;
                    pattern_d = fill_data_i;
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else if (fill_i) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (mem_ready_i) begin
                    data_d  = mem_rdata_i;
                    state_d = WR;
                end
            end
            WR: begin
                state_d = WAIT_WR;
            end
            WAIT_WR: begin
                if (mem_ready_i) begin
                    src_d = src_q + ADDRW'(1);
                    dst_d = dst_q + ADDRW'(1);
                    rem_d = rem_q - (ADDRW+1)'(1);
                    if (rem_q == (ADDRW+1)'(1)) begin
                        state_d = DONE;
                    end else if (fill_q) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state. This keeps the outputs registered
    // while the access still lines up with the RD/WR state. The address and
    // write data hold their last values between accesses.
    always_comb begin
        busy_d  = (state_d != IDLE) && (state_d != DONE);
        done_d  = (state_d == DONE);
        en_d    = (state_d == RD) || (state_d == WR);
        we_d    = (state_d == WR);
        be_d    = {BEW{we_d}};
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_d == RD) begin
            addr_d = src_d;
        end
        if (state_d == WR) begin
            addr_d  = dst_d;
            wdata_d = fill_d ? pattern_d : data_d;
        end
    end

    // State, datapath and output registers. Reset clears them all immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            fill_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            pattern_q <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            pattern_q <= pattern_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            en_q      <= en_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_en_o    = en_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_tcm_copy_engine.sv
// tb_tcm_copy_engine
// Directed bench for tcm_copy_engine. The bench contains a behavioural SRAM
// whose ready can be stalled. Expected values come from hand-computed constants.

module tb_tcm_copy_engine;

    localparam int DW = 32;
    localparam int NE = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          fill;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill_data;
    logic          busy;
    logic          done;
    logic          en;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;

    logic [DW-1:0] mem [NE];
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    int            stall_cycles;
    int            stall_cnt;
    int            write_count;
    int            en_count;
    int            consec_en;
    logic          prev_en;

    int tests_run;
    int tests_failed;

    tcm_copy_engine #(
        .DATA_WIDTH(DW),
        .N_ENTRIES (NE)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .fill_i     (fill),
        .src_addr_i (src),
        .dst_addr_i (dst),
        .len_i      (len),
        .fill_data_i(fill_data),
        .busy_o     (busy),
        .done_o     (done),
        .mem_en_o   (en),
        .mem_we_o   (we),
        .mem_be_o   (be),
        .mem_addr_o (addr),
        .mem_wdata_o(wdata),
        .mem_rdata_i(rdata),
        .mem_ready_i(ready)
    );

    always #5 clk = ~clk;

    // SRAM model: ready follows an access by 1 + stall_cycles cycles. The model
    // also counts accesses and back-to-back enables, and takes backdoor preloads.
    always @(posedge clk) begin
        prev_en <= en;
        if (en && prev_en) consec_en <= consec_en + 1;
        if (pl_we) mem[pl_addr] <= pl_data;
        if (!rst_n) begin
            ready     <= 1'b0;
            stall_cnt <= 0;
        end else begin
            ready <= 1'b0;
            if (en) begin
                en_count <= en_count + 1;
                if (we) begin
                    write_count <= write_count + 1;
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end else begin
                    rdata <= mem[addr];
                end
                stall_cnt <= stall_cycles;
                if (stall_cycles == 0) ready <= 1'b1;
            end else if (stall_cnt > 0) begin
                stall_cnt <= stall_cnt - 1;
                if (stall_cnt == 1) ready <= 1'b1;
            end
        end
    end

    // Watchdog so that the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hA5A5_0000 + DW'(i);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d_in);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d_in;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Starts one transfer at edge 0 and reports the cycle in which done_o was
    // seen, together with the number of cycles where busy_o was wrong. A second
    // start pulse carrying different inputs can be injected in cycle pulse_k.
    task automatic applyStimulus(input logic f, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                 input logic [AW:0] l, input logic [DW-1:0] fd,
                                 input int pulse_k, input int budget,
                                 output int done_k, output int busy_bad);
        @(negedge clk);
        start     = 1'b1;
        fill      = f;
        src       = s;
        dst       = d;
        len       = l;
        fill_data = fd;
        @(posedge clk);
        done_k   = -1;
        busy_bad = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = (k == pulse_k);
            if (k == pulse_k) begin
                fill      = ~f;
                src       = '0;
                dst       = '0;
                len       = 11'd1;
                fill_data = '1;
            end
            if (done) begin
                if (busy) busy_bad++;
                done_k = k;
                break;
            end else if (!busy) begin
                busy_bad++;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int done_k;
        int busy_bad;
        int w0;
        int e0;

        tests_run    = 0;
        tests_failed = 0;
        stall_cycles = 0;
        pl_we        = 1'b0;
        pl_addr      = '0;
        pl_data      = '0;
        start        = 1'b0;
        fill         = 1'b0;
        src          = '0;
        dst          = '0;
        len          = '0;
        fill_data    = '0;
        rst_n        = 1'b0;

        // Reset state
        #12;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_mem_outs", {38'(0), en, we, be, addr, wdata[7:0]}, 64'd0);
        checkOutput("reset_wdata", 64'(wdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) preload(AW'(10'h10 + i), pat(i));
        preload(10'h084, 32'h0);
        preload(10'h094, 32'h0);
        preload(10'h0A3, 32'h0);
        preload(10'h0B2, 32'h0);
        preload(10'h002, 32'h0BAD_F00D);

        // 1. Copy of four words
        w0 = write_count;
        e0 = en_count;
        applyStimulus(1'b0, 10'h010, 10'h080, 11'd4, 32'h0, 0, 100, done_k, busy_bad);
        checkOutput("copy_done_cycle", 64'(done_k), 64'd17);
        checkOutput("copy_busy_window", 64'(busy_bad), 64'd0);
        checkOutput("copy_writes", 64'(write_count - w0), 64'd4);
        checkOutput("copy_enables", 64'(en_count - e0), 64'd8);
        for (int i = 0; i < 4; i++) checkOutput("copy_word", 64'(mem[10'h080 + i]), 64'(pat(i)));
        checkOutput("copy_no_overrun", 64'(mem[10'h084]), 64'd0);
        @(negedge clk);
        checkOutput("copy_done_one_cycle", 64'(done), 64'd0);

        // 2. Fill that wraps past the top of memory
        w0 = write_count;
        applyStimulus(1'b1, 10'h000, 10'h3FE, 11'd4, 32'hDEAD_BEEF, 0, 100, done_k, busy_bad);
        checkOutput("fill_done_cycle", 64'(done_k), 64'd9);
        checkOutput("fill_busy_window", 64'(busy_bad), 64'd0);
        checkOutput("fill_writes", 64'(write_count - w0), 64'd4);
        checkOutput("fill_3fe", 64'(mem[10'h3FE]), 64'hDEAD_BEEF);
        checkOutput("fill_3ff", 64'(mem[10'h3FF]), 64'hDEAD_BEEF);
        checkOutput("fill_wrap_000", 64'(mem[10'h000]), 64'hDEAD_BEEF);
        checkOutput("fill_wrap_001", 64'(mem[10'h001]), 64'hDEAD_BEEF);
        checkOutput("fill_no_overrun", 64'(mem[10'h002]), 64'h0BAD_F00D);

        // 3. Zero-length request
        e0 = en_count;
        applyStimulus(1'b0, 10'h010, 10'h100, 11'd0, 32'h0, 0, 20, done_k, busy_bad);
        checkOutput("len0_done_cycle", 64'(done_k), 64'd1);
        checkOutput("len0_busy", 64'(busy_bad), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("len0_no_access", 64'(en_count - e0), 64'd0);

        // 4. Copy with ready stalled by three cycles on every access
        stall_cycles = 3;
        w0 = write_count;
        e0 = en_count;
        applyStimulus(1'b0, 10'h010, 10'h090, 11'd4, 32'h0, 0, 200, done_k, busy_bad);
        checkOutput("stall_done_cycle", 64'(done_k), 64'd41);
        checkOutput("stall_busy_window", 64'(busy_bad), 64'd0);
        checkOutput("stall_enables", 64'(en_count - e0), 64'd8);
        checkOutput("stall_writes", 64'(write_count - w0), 64'd4);
        for (int i = 0; i < 4; i++) checkOutput("stall_word", 64'(mem[10'h090 + i]), 64'(pat(i)));
        checkOutput("stall_no_overrun", 64'(mem[10'h094]), 64'd0);
        @(negedge clk);
        stall_cycles = 0;

        // 5. A second start while busy is ignored
        w0 = write_count;
        applyStimulus(1'b0, 10'h011, 10'h0A0, 11'd3, 32'h0, 3, 100, done_k, busy_bad);
        checkOutput("restart_done_cycle", 64'(done_k), 64'd13);
        checkOutput("restart_busy_window", 64'(busy_bad), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("restart_writes", 64'(write_count - w0), 64'd3);
        for (int i = 0; i < 3; i++) checkOutput("restart_word", 64'(mem[10'h0A0 + i]), 64'(pat(i + 1)));
        checkOutput("restart_no_overrun", 64'(mem[10'h0A3]), 64'd0);
        checkOutput("restart_idle", 64'(busy), 64'd0);

        // 6. Reset during WAIT_WR of word 2 of 8, then a fresh transfer
        w0 = write_count;
        @(negedge clk);
        start = 1'b1;
        fill  = 1'b0;
        src   = 10'h010;
        dst   = 10'h0B0;
        len   = 11'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("abort_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_mem_outs", {38'(0), en, we, be, addr, wdata[7:0]}, 64'd0);
        checkOutput("abort_wdata", 64'(wdata), 64'd0);
        checkOutput("abort_writes_before", 64'(write_count - w0), 64'd2);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort_writes_after", 64'(write_count - w0), 64'd2);
        checkOutput("abort_word0", 64'(mem[10'h0B0]), 64'(pat(0)));
        checkOutput("abort_word1", 64'(mem[10'h0B1]), 64'(pat(1)));
        checkOutput("abort_word2_untouched", 64'(mem[10'h0B2]), 64'd0);

        w0 = write_count;
        applyStimulus(1'b1, 10'h000, 10'h200, 11'd2, 32'h1234_5678, 0, 100, done_k, busy_bad);
        checkOutput("post_reset_done_cycle", 64'(done_k), 64'd5);
        checkOutput("post_reset_writes", 64'(write_count - w0), 64'd2);
        checkOutput("post_reset_word0", 64'(mem[10'h200]), 64'h1234_5678);
        checkOutput("post_reset_word1", 64'(mem[10'h201]), 64'h1234_5678);

        // The enable must never be high on two consecutive cycles.
        @(negedge clk);
        checkOutput("no_consecutive_enable", 64'(consec_en), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
